bcd_seg_display: RTL and testbench

BCD_SEG_DISPLAY -- requirements
Module: bcd_seg_display

---
 rtl/bcd_seg_display.sv | 178 +++++++++++++++++
 tb/tb_bcd_seg_display.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_display.sv
// bcd_seg_display: converts a 0..59 binary count to two BCD digits with a
// sequential double-dabble engine and drives a two-digit multiplexed,
// active-low 7-segment display.
// Optional feature macro: BCD_SEG_BLANK_EN (blank a leading zero in the tens digit).
module bcd_seg_display #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] cnt_in,
   input  logic       cnt_valid,
   output logic       busy,
   output logic       err,
   output logic [7:0] seg,
   output logic [1:0] sel
);

   localparam int          DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t        state_q, state_d;
   logic [13:0]   sr_q, sr_d;        // {tens, units, binary} shift register
   logic [2:0]    it_q, it_d;
   logic [5:0]    pend_q, pend_d;
   logic          pend_vld_q, pend_vld_d;
   logic          err_q, err_d;
   logic [3:0]    tens_q, tens_d, units_q, units_d;
   logic [DW-1:0] div_q, div_d;
   logic          digit_q, digit_d;
   logic [7:0]    seg_q, seg_d;
   logic [1:0]    sel_q, sel_d;

   logic          in_vld;
   logic [5:0]    in_val;

   // One double-dabble step: correct nibbles >= 5, then shift left.
   function automatic logic [13:0] dd_step(input logic [13:0] s);
      logic [3:0] t, u;
      t = s[13:10];
      u = s[9:6];
      if (u >= 4'd5) u = u + 4'd3;
      if (t >= 4'd5) t = t + 4'd3;
      return {t[2:0], u, s[5:0], 1'b0};
   endfunction

   function automatic logic [7:0] pat(input logic [3:0] d);
      case (d)
         4'd0:    pat = 8'hC0;
         4'd1:    pat = 8'hF9;
         4'd2:    pat = 8'hA4;
         4'd3:    pat = 8'hB0;
         4'd4:    pat = 8'h99;
         4'd5:    pat = 8'h92;
         4'd6:    pat = 8'h82;
         4'd7:    pat = 8'hF8;
         4'd8:    pat = 8'h80;
         4'd9:    pat = 8'h90;
         default: pat = 8'hFF;
      endcase
   endfunction

   // A live strobe in IDLE beats a value left pending from the last conversion.
   assign in_vld = cnt_valid | pend_vld_q;
   assign in_val = cnt_valid ? cnt_in : pend_q;
   assign busy   = (state_q != IDLE);
   assign err    = err_q;
   assign seg    = seg_q;
   assign sel    = sel_q;

   // Conversion FSM next-state, datapath and pending-sample capture.
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      it_d       = it_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      err_d      = err_q;
      tens_d     = tens_q;
      units_d    = units_q;
      case (state_q)
         IDLE: begin
            if (in_vld) begin
               pend_vld_d = 1'b0;
               if (in_val <= 6'd59) begin
                  sr_d    = {8'd0, in_val};
                  it_d    = 3'd0;
                  state_d = CONV;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         CONV: begin
            sr_d = dd_step(sr_q);
            it_d = it_q + 3'd1;
            if (it_q == 3'd5) state_d = DONE;
         end
         DONE: begin
            tens_d  = sr_q[13:10];
            units_d = sr_q[9:6];
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Samples arriving while busy park here; the newest one wins.
      if ((state_q != IDLE) && cnt_valid) begin
         pend_d     = cnt_in;
         pend_vld_d = 1'b1;
      end
   end

   // Conversion state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         it_q       <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         err_q      <= 1'b0;
         tens_q     <= '0;
         units_q    <= '0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         it_q       <= it_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         err_q      <= err_d;
         tens_q     <= tens_d;
         units_q    <= units_d;
      end
   end

   // Scan divider: wrap at SCAN_DIV-1 and flip the active digit.
   always_comb begin
      div_d   = div_q + 1'b1;
      digit_d = digit_q;
      if (div_q == LAST) begin
         div_d   = '0;
         digit_d = ~digit_q;
      end
   end

   // Segment/select decode; the dash for an error is never blanked.
   always_comb begin
      sel_d = digit_q ? 2'b01 : 2'b10;
      seg_d = pat(units_q);
      if (err_q) begin
         seg_d = 8'hBF;
      end else if (digit_q) begin
`ifdef BCD_SEG_BLANK_EN
         seg_d = (tens_q == 4'd0) ? 8'hFF : pat(tens_q);
`else
         seg_d = pat(tens_q);
`endif
      end
   end

   // Scan counter and registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= '0;
         digit_q <= 1'b0;
         seg_q   <= 8'hC0;
         sel_q   <= 2'b10;
      end else begin
         div_q   <= div_d;
         digit_q <= digit_d;
         seg_q   <= seg_d;
         sel_q   <= sel_d;
      end
   end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Self-checking bench for bcd_seg_display with SCAN_DIV=4.
module tb_bcd_seg_display;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] cnt_in = '0;
   logic       cnt_valid = 1'b0;
   logic       busy, err;
   logic [7:0] seg;
   logic [1:0] sel;

   int checks = 0;
   int errors = 0;

   // Reference model: what the display is currently showing.
   int cur_v   = 0;
   bit cur_err = 0;

`ifdef BCD_SEG_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic [7:0] pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   bcd_seg_display #(.SCAN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
      .busy(busy), .err(err), .seg(seg), .sel(sel)
   );

   always #5 clk = ~clk;

   // Expected segment byte for the observed select, value v and error flag e.
   function automatic logic [7:0] exp_seg(input logic [1:0] s, input int v, input bit e);
      if (s == 2'b10) return e ? 8'hBF : pat[v % 10];
      if (s == 2'b01) begin
         if (e) return 8'hBF;
         if (BLANK && (v / 10) == 0) return 8'hFF;
         return pat[v / 10];
      end
      return 8'h00;
   endfunction

   // Drive a one-cycle strobe; returns at the negedge after the accepting edge.
   task automatic send(input int v);
      cnt_in    = 6'(v);
      cnt_valid = 1'b1;
      @(negedge clk);
      cnt_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (seg !== 8'hC0) begin errors++; $display("FAIL reset_seg got %h want c0", seg); end
      checks++; if (sel !== 2'b10) begin errors++; $display("FAIL reset_sel got %b want 10", sel); end
      // Strobe present on the very first edge after release.
      rst_n = 1'b1;
      send(8);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_edge_accept busy got %b want 1", busy); end
      repeat (8) @(negedge clk);
      cur_v = 8; cur_err = 0;
      checks++; if (seg !== exp_seg(sel, cur_v, cur_err))
         begin errors++; $display("FAIL first_value seg got %h want %h sel %b", seg, exp_seg(sel, cur_v, cur_err), sel); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic;
      int prev, run;
      bit seen;
      logic [1:0] ps;
      prev = cur_v;
      send(37);
      for (int k = 0; k < 10; k++) begin
         checks++; if (busy !== (k < 7))
            begin errors++; $display("FAIL basic_busy k=%0d got %b want %b", k, busy, (k < 7)); end
         checks++; if (seg !== exp_seg(sel, (k < 8) ? prev : 37, 1'b0))
            begin errors++; $display("FAIL basic_seg k=%0d got %h want %h sel %b", k, seg, exp_seg(sel, (k < 8) ? prev : 37, 1'b0), sel); end
         if (k < 9) @(negedge clk);
      end
      cur_v = 37;
      // Slot alternation every 4 cycles.
      ps = sel; run = 0; seen = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++; if (seg !== exp_seg(sel, 37, 1'b0))
            begin errors++; $display("FAIL basic_hold seg got %h want %h sel %b", seg, exp_seg(sel, 37, 1'b0), sel); end
         if (sel == ps) run++;
         else begin
            if (seen) begin
               checks++; if (run != 4) begin errors++; $display("FAIL scan_period got %0d want 4", run); end
            end
            seen = 1; run = 1; ps = sel;
         end
      end
   endtask

   task automatic test_err;
      send(62);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b want 0", busy); end
      cur_err = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++; if (seg !== 8'hBF) begin errors++; $display("FAIL err_dash got %h want bf sel %b", seg, sel); end
      end
      send(5);
      for (int k = 0; k < 10; k++) begin
         checks++; if (err !== (k < 7)) begin errors++; $display("FAIL err_clear k=%0d got %b want %b", k, err, (k < 7)); end
         checks++; if (seg !== ((k < 8) ? exp_seg(sel, cur_v, 1'b1) : exp_seg(sel, 5, 1'b0)))
            begin errors++; $display("FAIL err_recover_seg k=%0d got %h sel %b", k, seg, sel); end
         if (k < 9) @(negedge clk);
      end
      cur_v = 5; cur_err = 0;
      repeat (4) @(negedge clk);
   endtask

   // First conversion of 20, then two strobes at k_a/k_b; final value fin shows.
   task automatic pend_run(input int k_a, input int va, input int k_b, input int vb, input int fin);
      logic [19:0] bb;
      int prev;
      prev = cur_v;
      send(20);
      bb[0] = busy;
      for (int k = 1; k < 20; k++) begin
         cnt_valid = (k == k_a) || (k == k_b);
         cnt_in    = 6'((k == k_a) ? va : vb);
         @(negedge clk);
         bb[k] = busy;
         checks++; if (seg !== exp_seg(sel, (k < 8) ? prev : ((k < 16) ? 20 : fin), 1'b0))
            begin errors++; $display("FAIL pend_seg k=%0d got %h sel %b fin %0d", k, seg, sel, fin); end
      end
      cnt_valid = 1'b0;
      checks++; if (bb !== 20'b00000_1111111_0_1111111)
         begin errors++; $display("FAIL pend_busy got %b want %b", bb, 20'b00000_1111111_0_1111111); end
      cur_v = fin;
   endtask

   task automatic test_back_to_back;
      pend_run(2, 12, 4, 45, 45);
   endtask

   task automatic test_done_priority;
      pend_run(2, 33, 7, 44, 44);
   endtask

   task automatic test_reset_mid;
      send(59);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b want 0", err); end
      checks++; if (seg !== 8'hC0) begin errors++; $display("FAIL rstmid_seg got %h want c0", seg); end
      checks++; if (sel !== 2'b10) begin errors++; $display("FAIL rstmid_sel got %b want 10", sel); end
      @(negedge clk);
      rst_n = 1'b1;
      cur_v = 0; cur_err = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++; if (busy !== 1'b0 || seg !== exp_seg(sel, 0, 1'b0))
            begin errors++; $display("FAIL rstmid_hold busy %b seg %h sel %b want %h", busy, seg, sel, exp_seg(sel, 0, 1'b0)); end
      end
   endtask

   task automatic test_sweep;
      int prev;
      bit pe;
      for (int v = 0; v < 60; v++) begin
         prev = cur_v; pe = cur_err;
         send(v);
         for (int k = 0; k < 10; k++) begin
            checks++; if (sel !== 2'b10 && sel !== 2'b01)
               begin errors++; $display("FAIL sweep_sel v=%0d got %b", v, sel); end
            checks++; if (seg !== ((k < 8) ? exp_seg(sel, prev, pe) : exp_seg(sel, v, 1'b0)))
               begin errors++; $display("FAIL sweep_seg v=%0d k=%0d got %h sel %b", v, k, seg, sel); end
            if (k < 9) @(negedge clk);
         end
         cur_v = v; cur_err = 0;
      end
   endtask

   task automatic test_random;
      int v;
      for (int n = 0; n < 40; n++) begin
         v = int'($urandom_range(0, 63));
         send(v);
         if (v > 59) begin
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL rand_err v=%0d got %b want 1", v, err); end
            cur_err = 1;
         end else begin
            cur_v = v; cur_err = 0;
         end
         repeat (9) @(negedge clk);
         checks++; if (err !== cur_err) begin errors++; $display("FAIL rand_errflag v=%0d got %b want %b", v, err, cur_err); end
         checks++; if (seg !== exp_seg(sel, cur_v, cur_err))
            begin errors++; $display("FAIL rand_seg v=%0d got %h want %h sel %b", v, seg, exp_seg(sel, cur_v, cur_err), sel); end
         repeat (int'($urandom_range(0, 3))) @(negedge clk);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_err;
      test_back_to_back;
      test_done_priority;
      test_reset_mid;
      test_sweep;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
